// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage feeding the IF/ID boundary.
// Owns the fetch PC, talks to instruction memory over a req/gnt/rvalid
// handshake with one request in flight, absorbs load-use stalls through
// a one-entry hold buffer and flushes on branch redirects from EX.
// Optional build macro: FETCH_PERF_CNT_EN adds FETCH_CNT / STALL_CNT.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_ID_write,
  input  logic        PCSrc,
  input  logic [31:0] PC_Branch,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] PC_ID,
  output logic [31:0] INSTRUCTION_ID,
  output logic        VALID_ID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;

  logic        req_en;
  logic        grant;
  logic        resp;
  logic        deliver;

  // Handshake decode: a request goes out only when decode can accept and
  // the hold buffer has room; a response only counts once one is in flight.
  always_comb begin
    req_en  = (state_q == ST_REQ) && IF_ID_write && !hold_full_q && !reset;
    grant   = req_en && IMEM_GNT;
    resp    = (state_q != ST_REQ) && IMEM_RVALID;
    deliver = (state_q == ST_WAIT) && IMEM_RVALID && !PCSrc;
  end

  assign IMEM_REQ       = req_en;
  assign IMEM_ADDR      = pc_f_q;
  assign PC_ID          = pc_id_q;
  assign INSTRUCTION_ID = instr_id_q;
  assign VALID_ID       = valid_id_q;

  // Next-state for the fetch FSM, PC, hold buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    req_pc_d     = req_pc_q;
    hold_full_d  = hold_full_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    valid_id_d   = valid_id_q;
    pc_id_d      = pc_id_q;
    instr_id_d   = instr_id_q;

    if (PCSrc) begin
      // Redirect beats stall: squash IF/ID and any buffered word, and
      // remember to throw away a response that is still on its way.
      pc_f_d      = PC_Branch & 32'hFFFF_FFFC;
      valid_id_d  = 1'b0;
      instr_id_d  = NOP_INSTR;
      hold_full_d = 1'b0;
      if (grant || ((state_q != ST_REQ) && !resp)) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (grant) begin
            pc_f_d   = pc_f_q + 32'd4;
            req_pc_d = pc_f_q;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT, ST_DISCARD: begin
          if (resp) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase

      if (IF_ID_write) begin
        if (hold_full_q) begin
          valid_id_d  = 1'b1;
          pc_id_d     = hold_pc_q;
          instr_id_d  = hold_instr_q;
          hold_full_d = 1'b0;
        end else if (deliver) begin
          valid_id_d = 1'b1;
          pc_id_d    = req_pc_q;
          instr_id_d = IMEM_RDATA;
        end else begin
          valid_id_d = 1'b0;
          instr_id_d = NOP_INSTR;
        end
      end else if (deliver) begin
        hold_full_d  = 1'b1;
        hold_pc_d    = req_pc_q;
        hold_instr_d = IMEM_RDATA;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_REQ;
      pc_f_q       <= RESET_PC;
      req_pc_q     <= RESET_PC;
      hold_full_q  <= 1'b0;
      hold_pc_q    <= 32'd0;
      hold_instr_q <= NOP_INSTR;
      valid_id_q   <= 1'b0;
      pc_id_q      <= 32'd0;
      instr_id_q   <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      req_pc_q     <= req_pc_d;
      hold_full_q  <= hold_full_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      valid_id_q   <= valid_id_d;
      pc_id_q      <= pc_id_d;
      instr_id_q   <= instr_id_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        load_valid;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count real instructions entering IF/ID and cycles decode held us off.
  always_comb begin
    load_valid  = IF_ID_write && !PCSrc && (hold_full_q || deliver);
    fetch_cnt_d = fetch_cnt_q + {31'd0, load_valid};
    stall_cnt_d = stall_cnt_q + {31'd0, !IF_ID_write};
  end

  // Counter registers, cleared by reset and free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus randomized run against a
// transaction-level model of the fetch stage and a variable-latency memory.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;

  logic        clk;
  logic        reset;
  logic        IF_ID_write;
  logic        PCSrc;
  logic [31:0] PC_Branch;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] PC_ID;
  logic [31:0] INSTRUCTION_ID;
  logic        VALID_ID;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FETCH_CNT;
  logic [31:0] STALL_CNT;
`endif

  int total = 0;
  int bad   = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .reset         (reset),
    .IF_ID_write   (IF_ID_write),
    .PCSrc         (PCSrc),
    .PC_Branch     (PC_Branch),
    .IMEM_REQ      (IMEM_REQ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_GNT      (IMEM_GNT),
    .IMEM_RVALID   (IMEM_RVALID),
    .IMEM_RDATA    (IMEM_RDATA),
    .PC_ID         (PC_ID),
    .INSTRUCTION_ID(INSTRUCTION_ID),
    .VALID_ID      (VALID_ID)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FETCH_CNT     (FETCH_CNT),
    .STALL_CNT     (STALL_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ifw, pcs;
    logic [31:0] br;
    logic        gnt, rv;
    logic [31:0] rd;
    logic        e_req, chk_addr;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  function automatic vec_t v(input logic rst, ifw, pcs, input logic [31:0] br,
                             input logic gnt, rv, input logic [31:0] rd,
                             input logic e_req, chk_addr, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_pc, e_instr);
    vec_t r;
    r.rst = rst; r.ifw = ifw; r.pcs = pcs; r.br = br;
    r.gnt = gnt; r.rv = rv; r.rd = rd;
    r.e_req = e_req; r.chk_addr = chk_addr; r.e_addr = e_addr;
    r.e_valid = e_valid; r.e_pc = e_pc; r.e_instr = e_instr;
    return r;
  endfunction

  // Reference model: fetch PC, one-deep in-flight tracking, hold buffer, IF/ID.
  logic [31:0] m_pc, m_out_pc, m_hpc, m_hinstr, m_pcid, m_instr;
  bit          m_out, m_disc, m_hfull, m_valid;
  logic [31:0] m_fetch, m_stall;

  // Memory model: one pending response with a countdown.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a << 7) ^ 32'h5EED_0013 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic bit modelReq(input bit rst, input bit ifw);
    return !rst && !m_out && ifw && !m_hfull;
  endfunction

  task automatic modelStep(input bit rst, ifw, pcs, input logic [31:0] br,
                           input bit gnt, rv, input logic [31:0] rd);
    bit acc, resp, dlv;
    logic [31:0] d_pc;
    if (rst) begin
      m_pc = 32'd0; m_out = 0; m_disc = 0; m_hfull = 0;
      m_valid = 0; m_pcid = 32'd0; m_instr = NOP;
      m_fetch = 32'd0; m_stall = 32'd0;
      return;
    end
    acc  = modelReq(0, ifw) && gnt;
    resp = m_out && rv;
    dlv  = resp && !m_disc && !pcs;
    d_pc = m_out_pc;
    if (!ifw) m_stall = m_stall + 32'd1;
    if (pcs) begin
      m_out   = acc || (m_out && !rv);
      m_disc  = m_out;
      m_pc    = br & ~32'd3;
      m_valid = 0;
      m_instr = NOP;
      m_hfull = 0;
    end else begin
      if (resp) m_out = 0;
      if (acc) begin
        m_out_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_out    = 1;
        m_disc   = 0;
      end
      if (ifw) begin
        if (m_hfull) begin
          m_valid = 1; m_pcid = m_hpc; m_instr = m_hinstr; m_hfull = 0;
          m_fetch = m_fetch + 32'd1;
        end else if (dlv) begin
          m_valid = 1; m_pcid = d_pc; m_instr = rd;
          m_fetch = m_fetch + 32'd1;
        end else begin
          m_valid = 0; m_instr = NOP;
        end
      end else if (dlv) begin
        m_hfull = 1; m_hpc = d_pc; m_hinstr = rd;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample the request
  // side before the rising edge, then let the registers settle.
  task automatic applyStimulus(input logic rst, ifw, pcs, input logic [31:0] br,
                               input logic gnt, rv, input logic [31:0] rd,
                               output logic req_o, output logic [31:0] addr_o);
    @(negedge clk);
    reset       = rst;
    IF_ID_write = ifw;
    PCSrc       = pcs;
    PC_Branch   = br;
    IMEM_GNT    = gnt;
    IMEM_RVALID = rv;
    IMEM_RDATA  = rd;
    #1;
    req_o  = IMEM_REQ;
    addr_o = IMEM_ADDR;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t        vecs[$];
    logic        act_req, exp_req;
    logic [31:0] act_addr, exp_addr;
    logic        rst, ifw, pcs, gnt, rv;
    logic [31:0] br, rd;

    reset = 1'b1; IF_ID_write = 1'b1; PCSrc = 1'b0; PC_Branch = 32'd0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'd0;

    //             rst ifw pcs br            gnt rv  rd            req chk addr          vld pc_id         instr
    vecs.push_back(v(H, H, L, 32'h0,         L, L, 32'h0,         L, L, 32'h0,         L, 32'h0,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'h0,         L, 32'h0,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         H, H, 32'hA000_0001, L, H, 32'h4,         H, 32'h0,         32'hA000_0001));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'h4,         L, 32'h0,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         L, H, 32'hA000_0002, L, H, 32'h8,         H, 32'h4,         32'hA000_0002));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'h8,         L, 32'h4,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         L, H, 32'hA000_0003, L, H, 32'hC,         H, 32'h8,         32'hA000_0003));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'hC,         L, 32'h8,         NOP));
    vecs.push_back(v(L, L, L, 32'h0,         H, H, 32'hA000_0004, L, H, 32'h10,        L, 32'h8,         NOP));
    vecs.push_back(v(L, L, L, 32'h0,         H, L, 32'h0,         L, H, 32'h10,        L, 32'h8,         NOP));
    vecs.push_back(v(L, L, L, 32'h0,         H, L, 32'h0,         L, H, 32'h10,        L, 32'h8,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         L, H, 32'h10,        H, 32'hC,         32'hA000_0004));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'h10,        L, 32'hC,         NOP));
    vecs.push_back(v(L, H, H, 32'h103,       H, L, 32'h0,         L, H, 32'h14,        L, 32'hC,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         H, H, 32'hDEAD_BEEF, L, H, 32'h100,       L, 32'hC,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'h100,       L, 32'hC,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         L, H, 32'hA000_0005, L, H, 32'h104,       H, 32'h100,       32'hA000_0005));
    vecs.push_back(v(L, L, H, 32'hFFFF_FFFC, H, L, 32'h0,         L, H, 32'h104,       L, 32'h100,       NOP));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'hFFFF_FFFC, L, 32'h100,       NOP));
    vecs.push_back(v(L, H, L, 32'h0,         L, H, 32'hA000_0006, L, H, 32'h0,         H, 32'hFFFF_FFFC, 32'hA000_0006));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'h0,         L, 32'hFFFF_FFFC, NOP));
    vecs.push_back(v(H, H, L, 32'h0,         H, L, 32'h0,         L, H, 32'h4,         L, 32'h0,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         L, L, 32'h0,         H, H, 32'h0,         L, 32'h0,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         H, L, 32'h0,         H, H, 32'h0,         L, 32'h0,         NOP));
    vecs.push_back(v(L, H, L, 32'h0,         L, H, 32'hA000_0007, L, H, 32'h4,         H, 32'h0,         32'hA000_0007));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].ifw, vecs[k].pcs, vecs[k].br,
                    vecs[k].gnt, vecs[k].rv, vecs[k].rd, act_req, act_addr);
      checkOutput($sformatf("tbl%0d_req", k), {31'd0, act_req}, {31'd0, vecs[k].e_req});
      if (vecs[k].chk_addr)
        checkOutput($sformatf("tbl%0d_addr", k), act_addr, vecs[k].e_addr);
      checkOutput($sformatf("tbl%0d_valid", k), {31'd0, VALID_ID}, {31'd0, vecs[k].e_valid});
      checkOutput($sformatf("tbl%0d_pc", k), PC_ID, vecs[k].e_pc);
      checkOutput($sformatf("tbl%0d_instr", k), INSTRUCTION_ID, vecs[k].e_instr);
    end

`ifdef FETCH_PERF_CNT_EN
    // Five zero-wait fetches then two stall cycles.
    applyStimulus(H, H, L, 32'h0, L, L, 32'h0, act_req, act_addr);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(L, H, L, 32'h0, H, L, 32'h0, act_req, act_addr);
      applyStimulus(L, H, L, 32'h0, L, H, 32'h1234_0000 + k, act_req, act_addr);
    end
    applyStimulus(L, L, L, 32'h0, L, L, 32'h0, act_req, act_addr);
    applyStimulus(L, L, L, 32'h0, L, L, 32'h0, act_req, act_addr);
    checkOutput("perf_fetch", FETCH_CNT, 32'd5);
    checkOutput("perf_stall", STALL_CNT, 32'd2);
`endif

    // Randomized run against the model and a variable-latency memory.
    mem_pend = 0; mem_cnt = 0; mem_addr = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 299) == 0);
      ifw = ($urandom_range(0, 3) != 0);
      pcs = ($urandom_range(0, 15) == 0);
      br  = $urandom;
      gnt = ($urandom_range(0, 2) != 0);
      rv  = mem_pend && (mem_cnt == 0);
      rd  = rv ? memWord(mem_addr) : $urandom;
      exp_req  = modelReq(rst, ifw);
      exp_addr = m_pc;
      applyStimulus(rst, ifw, pcs, br, gnt, rv, rd, act_req, act_addr);
      checkOutput($sformatf("rnd%0d_req", i), {31'd0, act_req}, {31'd0, exp_req});
      if (i > 0) checkOutput($sformatf("rnd%0d_addr", i), act_addr, exp_addr);

      if (rst) begin
        mem_pend = 0;
      end else begin
        if (rv) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (act_req && gnt) begin
          mem_pend = 1;
          mem_cnt  = $urandom_range(0, 2);
          mem_addr = act_addr;
        end
      end

      modelStep(rst, ifw, pcs, br, gnt, rv, rd);
      checkOutput($sformatf("rnd%0d_valid", i), {31'd0, VALID_ID}, {31'd0, m_valid});
      checkOutput($sformatf("rnd%0d_pc", i), PC_ID, m_pcid);
      checkOutput($sformatf("rnd%0d_instr", i), INSTRUCTION_ID, m_instr);
`ifdef FETCH_PERF_CNT_EN
      checkOutput($sformatf("rnd%0d_fcnt", i), FETCH_CNT, m_fetch);
      checkOutput($sformatf("rnd%0d_scnt", i), STALL_CNT, m_stall);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake with variable latency and at most one request outstanding.
- Registers PC and instruction into the IF/ID boundary, so PC_ID and INSTRUCTION_ID feed decode directly.
- Handles load-use stalls from the hazard unit and branch redirect/flush from EX.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.
- NOP_INSTR, 32'h00000013, instruction word (addi x0,x0,0) driven on INSTRUCTION_ID when VALID_ID=0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IF_ID_write  in  1  0 = stall: hold the PC and the IF/ID outputs.
- PCSrc  in  1  branch/jump taken in EX: redirect and flush.
- PC_Branch  in  32  redirect target, valid when PCSrc=1.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address, word aligned.
- IMEM_GNT  in  1  request accepted this cycle when IMEM_REQ=1.
- IMEM_RVALID  in  1  response data valid; responses arrive in order, at least 1 cycle after grant.
- IMEM_RDATA  in  32  instruction word.
- PC_ID  out  32  PC of the instruction currently in IF/ID.
- INSTRUCTION_ID  out  32  instruction to decode.
- VALID_ID  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (synchronous, highest priority, including mid-transaction):
  - PC_F=RESET_PC, FSM=REQ.
  - VALID_ID=0, PC_ID=0, INSTRUCTION_ID=NOP_INSTR, hold buffer empty, IMEM_REQ=0 during the reset cycle.
  - Any response already in flight is ignored; the memory side is also reset.
- FSM states:
  - REQ: IMEM_REQ=1 only if IF_ID_write=1 and the hold buffer is empty; IMEM_ADDR=PC_F. On IMEM_GNT: PC_F<=PC_F+4, go to WAIT.
  - WAIT: IMEM_REQ=0. On IMEM_RVALID: deliver the word, go to REQ.
  - DISCARD: IMEM_REQ=0. On IMEM_RVALID: drop the word, go to REQ.
- Delivery of a word with its request PC:
  - IF_ID_write=1 and hold buffer empty: load IF/ID next edge with VALID_ID=1.
  - IF_ID_write=0: write the hold buffer, full=1.
- IF/ID register:
  - When IF_ID_write=1, updates every cycle.
  - Source priority: hold buffer, then RVALID word, else bubble (VALID_ID=0, INSTRUCTION_ID=NOP_INSTR, PC_ID unchanged).
  - When IF_ID_write=0, all IF/ID outputs hold.
- Redirect (PCSrc=1; beats stall, loses to reset):
  - PC_F<=PC_Branch, VALID_ID<=0, INSTRUCTION_ID<=NOP_INSTR, hold buffer cleared.
  - If in WAIT, or in REQ with IMEM_GNT this cycle, go to DISCARD; otherwise stay in REQ.
  - An RVALID in the same cycle as PCSrc is dropped.
- Arithmetic and sequencing:
  - PC_F+4 is mod 2^32; 32'hFFFFFFFC wraps to 0.
  - PC_Branch[1:0] is forced to 0.
  - Zero-wait memory (RVALID the cycle after GNT) gives one instruction every 2 cycles; no throughput requirement beyond that.
- Invariants:
  - At most one outstanding request.
  - The hold buffer is never overwritten while full; requests are blocked while it is full.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs FETCH_CNT[31:0] and STALL_CNT[31:0].
  - FETCH_CNT increments when IF/ID loads with VALID_ID=1.
  - STALL_CNT increments each cycle IF_ID_write=0.
  - Both clear on reset and wrap at 2^32.
- Undefined: the ports and logic do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, memory always GNT with RVALID 1 cycle later -> IMEM_ADDR 0,4,8; VALID_ID pulses with PC_ID 0,4,8 and INSTRUCTION_ID = memory word.
- IF_ID_write=0 for 3 cycles while a request is in WAIT -> the response goes to the hold buffer and IF/ID holds; no IMEM_REQ during the stall; after release, IF/ID shows the held word the next cycle.
- PCSrc=1, PC_Branch=32'h100 while in WAIT -> the late response is dropped, VALID_ID=0 with INSTRUCTION_ID=32'h00000013, next IMEM_ADDR=32'h100.
- PCSrc and IF_ID_write=0 in the same cycle -> flush wins: VALID_ID=0 and PC_F=PC_Branch.
- PC_F=32'hFFFFFFFC fetched -> next IMEM_ADDR=32'h0; reset asserted during WAIT -> outputs return to their reset values the next cycle and fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN defined, 5 fetches and 2 stall cycles -> FETCH_CNT=5, STALL_CNT=2.
